// File: rtl/rf_trans_pkg.sv
// rtl/rf_trans_pkg.sv - shared state encoding, header length and default timing for the RF transmit path
package rf_trans_pkg;

    typedef enum logic [1:0] {
        SELF_CHECK = 2'd0,
        IDLE       = 2'd1,
        SEND       = 2'd2,
        POST_WAIT  = 2'd3
    } tx_state_t;

    localparam int HDR_LEN = 3;

    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_BUF_DEPTH         = 512;
    localparam int DEF_START_THRESHOLD   = 58;
    localparam int DEF_MAX_PACKET        = 58;
    localparam int DEF_GAP_CYCLES        = 6511;
    localparam int DEF_POST_WAIT_CYCLES  = 625000;
    localparam int DEF_SELF_CHECK_CYCLES = 31250;

endpackage

// File: rtl/rf_sync_fifo.sv
// rtl/rf_sync_fifo.sv - single-clock byte FIFO with level, full/empty and synchronous clear
module rf_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 512
) (
    input  logic                       internal_clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic [$clog2(BUF_DEPTH):0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge internal_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at BUF_DEPTH; level tracks stored entries.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_tx_packetizer.sv
// rtl/rf_tx_packetizer.sv - MCU-to-node RF transmit packetizer; RF_FIXED_HEADER_EN adds a 3-byte header
module rf_tx_packetizer
    import rf_trans_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int BUF_DEPTH         = DEF_BUF_DEPTH,
    parameter int START_THRESHOLD   = DEF_START_THRESHOLD,
    parameter int MAX_PACKET        = DEF_MAX_PACKET,
    parameter int GAP_CYCLES        = DEF_GAP_CYCLES,
    parameter int POST_WAIT_CYCLES  = DEF_POST_WAIT_CYCLES,
    parameter int SELF_CHECK_CYCLES = DEF_SELF_CHECK_CYCLES
) (
    input  logic                       internal_clk,
    input  logic                       rst_n,
    input  logic                       tx_en,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    input  logic                       flush,
`ifdef RF_FIXED_HEADER_EN
    input  logic [DATA_WIDTH-1:0]      hdr_addh,
    input  logic [DATA_WIDTH-1:0]      hdr_addl,
    input  logic [DATA_WIDTH-1:0]      hdr_chan,
`endif
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       aux,
    output logic [$clog2(BUF_DEPTH):0] level,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int LW   = $clog2(BUF_DEPTH) + 1;
    localparam int CW   = $clog2(MAX_PACKET + HDR_LEN + 1);
    localparam int GW   = $clog2(GAP_CYCLES + 1);
    localparam int WMAX = (POST_WAIT_CYCLES > SELF_CHECK_CYCLES) ? POST_WAIT_CYCLES : SELF_CHECK_CYCLES;
    localparam int WW   = $clog2(WMAX + 1);
`ifdef RF_FIXED_HEADER_EN
    localparam int HL = HDR_LEN;
`else
    localparam int HL = 0;
`endif
    localparam logic [LW-1:0] START_L = LW'(START_THRESHOLD);
    localparam logic [LW-1:0] MAXP_L  = LW'(MAX_PACKET);
    localparam logic [CW-1:0] MAXP_C  = CW'(MAX_PACKET);
    localparam logic [CW-1:0] HL_C    = CW'(HL);
    localparam logic [GW-1:0] GAP_L   = GW'(GAP_CYCLES);
    localparam logic [WW-1:0] SC_LAST = WW'(SELF_CHECK_CYCLES - 1);
    localparam logic [WW-1:0] PW_LAST = WW'(POST_WAIT_CYCLES - 1);

    tx_state_t             state;
    tx_state_t             next_state;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_clear;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [LW-1:0]         fifo_level;
    logic [GW-1:0]         gap_cnt;
    logic [WW-1:0]         wait_cnt;
    logic [CW-1:0]         pkt_total;
    logic [CW-1:0]         pkt_total_next;
    logic [CW-1:0]         emit_cnt;
    logic [CW-1:0]         xfer_cnt;
    logic                  start;
    logic                  load;
    logic                  xfer;
    logic                  payload_slot;
    logic [DATA_WIDTH-1:0] load_data;

    assign fifo_clear     = (state == IDLE) && flush;
    assign fifo_push      = in_valid && !fifo_full && !fifo_clear;
    assign xfer           = out_valid && out_ready;
    assign pkt_total_next = ((fifo_level < MAXP_L) ? CW'(fifo_level) : MAXP_C) + HL_C;
    assign fifo_pop       = load && payload_slot;
    assign level          = fifo_level;

    rf_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .internal_clk (internal_clk),
        .rst_n        (rst_n),
        .clear        (fifo_clear),
        .push         (fifo_push),
        .push_data    (in_data),
        .pop          (fifo_pop),
        .pop_data     (fifo_rdata),
        .level        (fifo_level),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

`ifdef RF_FIXED_HEADER_EN
    logic [DATA_WIDTH-1:0] hdr_addh_q;
    logic [DATA_WIDTH-1:0] hdr_addl_q;
    logic [DATA_WIDTH-1:0] hdr_chan_q;

    // Header fields are frozen when the packet opens so they cannot change mid-packet.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_addh_q <= '0;
            hdr_addl_q <= '0;
            hdr_chan_q <= '0;
        end else if (start) begin
            hdr_addh_q <= hdr_addh;
            hdr_addl_q <= hdr_addl;
            hdr_chan_q <= hdr_chan;
        end
    end

    // The first HL output slots carry header bytes, the rest come from the buffer.
    always_comb begin
        payload_slot = 1'b1;
        load_data    = fifo_rdata;
        if (emit_cnt < HL_C) begin
            payload_slot = 1'b0;
            case (emit_cnt[1:0])
                2'd0:    load_data = hdr_addh_q;
                2'd1:    load_data = hdr_addl_q;
                default: load_data = hdr_chan_q;
            endcase
        end
    end
`else
    assign payload_slot = 1'b1;
    assign load_data    = fifo_rdata;
`endif

    // State register.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SELF_CHECK;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus packet-open and output-load strobes.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        load       = 1'b0;
        case (state)
            SELF_CHECK: begin
                if (wait_cnt == SC_LAST) next_state = IDLE;
            end
            IDLE: begin
                if (!flush && tx_en &&
                    (fifo_level >= START_L || (fifo_level != '0 && gap_cnt == GAP_L))) begin
                    next_state = SEND;
                    start      = 1'b1;
                end
            end
            SEND: begin
                if (emit_cnt != pkt_total && (!out_valid || out_ready) &&
                    (!payload_slot || !fifo_empty)) begin
                    load = 1'b1;
                end
                if (xfer && xfer_cnt == pkt_total - CW'(1)) next_state = POST_WAIT;
            end
            POST_WAIT: begin
                if (wait_cnt == PW_LAST) next_state = IDLE;
            end
            default: next_state = SELF_CHECK;
        endcase
    end

    // Shared timer for the self-check window and the post-packet guard gap.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (state == SELF_CHECK || state == POST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Quiet-line detector: restarts on every stored byte, idles at zero when empty.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (fifo_push || fifo_level == '0) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_L) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Packet length latch plus loaded/transferred byte counters.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_total <= '0;
            emit_cnt  <= '0;
            xfer_cnt  <= '0;
        end else if (start) begin
            pkt_total <= pkt_total_next;
            emit_cnt  <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (load) emit_cnt <= emit_cnt + 1'b1;
            if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    // Registered output stage; data holds until the node UART takes it.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // AUX high only when idle with nothing buffered or in flight.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            aux <= 1'b0;
        end else begin
            aux <= (state == IDLE) && (fifo_level == '0) && !out_valid;
        end
    end

endmodule

// File: tb/tb_rf_tx_packetizer.sv
// tb/tb_rf_tx_packetizer.sv - scoreboard bench for rf_tx_packetizer
module tb_rf_tx_packetizer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int START = 8;
    localparam int MAXP  = 6;
    localparam int GAP   = 20;
    localparam int PW    = 10;
    localparam int SC    = 5;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          internal_clk = 1'b0;
    logic          rst_n        = 1'b0;
    logic          tx_en        = 1'b0;
    logic [DW-1:0] in_data      = '0;
    logic          in_valid     = 1'b0;
    logic          flush        = 1'b0;
    logic          out_ready    = 1'b0;
    logic          ovf_clr      = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          aux;
    logic [LW-1:0] level;
    logic          overflow;

    int            checks    = 0;
    int            fails     = 0;
    int            rx_count  = 0;
    int            stall_cnt = 0;
    int            rx0;
    logic [DW-1:0] exp_q [$];
    logic          stall_pending = 1'b0;
    logic [DW-1:0] held_data     = '0;

    always #5 internal_clk = ~internal_clk;

    rf_tx_packetizer #(
        .DATA_WIDTH        (DW),
        .BUF_DEPTH         (DEPTH),
        .START_THRESHOLD   (START),
        .MAX_PACKET        (MAXP),
        .GAP_CYCLES        (GAP),
        .POST_WAIT_CYCLES  (PW),
        .SELF_CHECK_CYCLES (SC)
    ) dut (
        .internal_clk (internal_clk),
        .rst_n        (rst_n),
        .tx_en        (tx_en),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .aux          (aux),
        .level        (level),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge internal_clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [DW-1:0] b, input bit expect_out);
        in_valid = 1'b1;
        in_data  = b;
        if (expect_out) exp_q.push_back(b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_aux(input string tag, input int budget);
        int n = 0;
        while (!aux && n < budget) begin
            step();
            n++;
        end
        check(tag, aux, 1);
    endtask

    // Output monitor: compares every transfer against the scoreboard and checks stall hold.
    always @(negedge internal_clk) begin
        if (rst_n) begin
            if (stall_pending) begin
                stall_cnt++;
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                check("sb_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
                rx_count++;
            end
            stall_pending = out_valid && !out_ready;
            held_data     = out_data;
        end else begin
            stall_pending = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int early;
        int n;

        step(2);
        check("rst_aux", aux, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        for (int i = 0; i < SC; i++) begin
            step();
            check("selfcheck_aux_low", aux, 0);
            check("selfcheck_no_valid", out_valid, 0);
        end
        wait_aux("selfcheck_aux_high", 3);
        check("selfcheck_level", level, 0);

        // Threshold start: 8 bytes split into 6 + 2.
        tx_en     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(DW'(8'h11 + i), 1'b1);
        wait_valid("pkt1_start", 10);
        for (int i = 0; i < MAXP; i++) begin
            check("pkt1_consecutive", out_valid, 1);
            step();
        end
        check("pkt1_len_bounded", out_valid, 0);
        g = 0;
        while (!out_valid && g < 100) begin
            step();
            g++;
        end
        check("pkt_gap_ge_post_wait", g >= PW, 1);
        wait_drain("pkt2_drain", 20);
        wait_aux("pkt2_aux_back", 40);
        check("pkt2_level", level, 0);

        // Quiet-line flush of a partial buffer.
        rx0 = rx_count;
        for (int i = 0; i < 3; i++) push_byte(DW'(8'hA0 + i), 1'b1);
        early = 0;
        repeat (15) begin
            step();
            if (out_valid) early = 1;
        end
        check("gap_no_early_start", early, 0);
        wait_valid("gap_start", 20);
        wait_drain("gap_drain", 20);
        check("gap_count", rx_count - rx0, 3);
        check("gap_level", level, 0);
        wait_aux("gap_aux_back", 40);

        // Back-pressure: out_ready toggles each cycle.
        rx0 = rx_count;
        for (int i = 0; i < 6; i++) push_byte(DW'(8'h01 + i), 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            out_ready = ~out_ready;
            step();
            n++;
        end
        out_ready = 1'b1;
        check("bp_drained", exp_q.size(), 0);
        check("bp_count", rx_count - rx0, 6);
        check("bp_stalls_seen", stall_cnt > 0, 1);
        wait_aux("bp_aux_back", 40);
        check("bp_level", level, 0);

        // Overflow with tx disabled, then readout proves the 17th byte was dropped.
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(DW'(8'h30 + i), 1'b0);
        check("ovf_level_full", level, 16);
        check("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(DW'(8'h30 + i));
        tx_en = 1'b1;
        wait_drain("ovf_readout", 200);
        wait_aux("ovf_aux_back", 40);
        check("ovf_readout_level", level, 0);

        // Flush in IDLE empties the buffer.
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(DW'(8'h60 + i), 1'b0);
        check("flush_pre_level", level, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_level", level, 0);

        // Asynchronous reset in the middle of a packet.
        tx_en = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(DW'(8'h70 + i), 1'b1);
        wait_valid("rst_mid_send_start", 10);
        step(2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_aux", aux, 0);
        check("rst_mid_level", level, 0);
        exp_q.delete();
        tx_en = 1'b0;
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < SC; i++) begin
            step();
            check("rst_mid_selfcheck_aux_low", aux, 0);
        end
        wait_aux("rst_mid_selfcheck_aux_high", 3);
        check("rst_mid_final_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rf_tx_packetizer.md
Name: rf_tx_packetizer

Overview:
Parametrised wireless-transmit packetizer between the MCU-side UART receive path and the node-side UART transmit path of the RF transceiver. It buffers MCU bytes and opens a packet when a fill threshold is reached or the MCU line goes quiet. It streams packets of bounded length to the node UART with a guard gap between packets, and drives the busy/AUX indication, including a post-reset self-check window.

Parameters:
DATA_WIDTH, 8, byte width on both sides
BUF_DEPTH, 512, buffer entries; must be a power of 2
START_THRESHOLD, 58, stored-byte count that opens a packet immediately
MAX_PACKET, 58, maximum payload bytes per packet
GAP_CYCLES, 6511, quiet cycles after the last accepted byte that flush a partial buffer
POST_WAIT_CYCLES, 625000, guard cycles after each packet
SELF_CHECK_CYCLES, 31250, AUX-low cycles after reset

Ports:
internal_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tx_en  in  1  transmission allowed (mode-controller derived)
in_data  in  DATA_WIDTH  byte from MCU UART
in_valid  in  1  one-cycle strobe, in_data valid
flush  in  1  discard buffer contents; honoured in IDLE only
out_data  out  DATA_WIDTH  byte to node UART
out_valid  out  1  out_data valid
out_ready  in  1  node UART can accept (not FIFO-full)
aux  out  1  1 = idle and empty, 0 = busy
level  out  clog2(BUF_DEPTH)+1  bytes currently stored
overflow  out  1  sticky: a byte was dropped
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (async, rst_n=0): state SELF_CHECK, buffer empty, level=0, out_valid=0, out_data=0, aux=0, overflow=0, all counters 0.
- States:
  - SELF_CHECK: count SELF_CHECK_CYCLES, then go to IDLE. Input bytes are accepted. No transmission.
  - IDLE: go to SEND when tx_en=1 and (level>=START_THRESHOLD, or level>0 with gap counter == GAP_CYCLES).
    - On entry to SEND, latch pkt_len = min(level, MAX_PACKET).
    - flush=1 in IDLE empties the buffer that cycle; flush takes priority over a push.
  - SEND: emit pkt_len bytes, then go to POST_WAIT.
  - POST_WAIT: count POST_WAIT_CYCLES, then go to IDLE. IDLE re-evaluates the start condition in its first cycle.
- Gap counter:
  - Cleared on every accepted push.
  - Increments while level>0, saturating at GAP_CYCLES.
  - Held at 0 while level=0.
- Push:
  - Accepted when in_valid=1 and level<BUF_DEPTH, in any state.
  - When full, the byte is dropped and overflow is set. This applies even if a pop occurs in the same cycle.
  - ovf_clr clears overflow; a drop in the same cycle wins.
- Output handshake:
  - Registered output stage. A buffer pop loads out_data/out_valid one cycle later.
  - Transfer occurs when out_valid & out_ready. out_data is held stable until accepted.
  - Maximum one byte per cycle with back-to-back pops.
  - A payload byte counter counts transfers. At pkt_len transfers, out_valid falls in the next cycle.
- tx_en falling during SEND does not abort; the current packet completes.
- level counts stored buffer bytes only, not the output register. Simultaneous push and pop leaves level unchanged.
- aux = 1 only in IDLE with level==0 and out_valid==0; otherwise 0. aux is registered (1-cycle lag vs state).
- Pointer wrap: read/write pointers are clog2(BUF_DEPTH) bits and wrap naturally.

Optional Feature:
Macro RF_FIXED_HEADER_EN.
- Defined:
  - Adds ports hdr_addh, hdr_addl, hdr_chan (in, DATA_WIDTH each).
  - These are sampled on IDLE->SEND.
  - SEND emits these three bytes first, in order, then the payload.
  - Header bytes do not count toward MAX_PACKET and are not read from the buffer.
  - Same valid/ready rules apply.
- Undefined: ports absent; packets are payload only.

Decomposition:
- Package rf_trans_pkg:
  - state enum {SELF_CHECK, IDLE, SEND, POST_WAIT}
  - HDR_LEN=3
  - default timing constants shared with controller_RF_transceiver
- Sub-module rf_sync_fifo (BUF_DEPTH, DATA_WIDTH):
  - push/pop/level/full/empty
  - async active-low reset on internal_clk/rst_n

Test Plan:
Bench params: BUF_DEPTH=16, START_THRESHOLD=8, MAX_PACKET=6, GAP_CYCLES=20, POST_WAIT_CYCLES=10, SELF_CHECK_CYCLES=5.
- Reset released -> aux=0 for 5 cycles, then aux=1; out_valid=0 throughout; level=0.
- Push 8 bytes 0x11..0x18 with tx_en=1, out_ready=1:
  - 0x11..0x16 emitted consecutively.
  - After 10 idle cycles, 0x17,0x18 emitted as the second packet.
  - aux returns to 1 after the second guard gap.
- Push 3 bytes 0xA0..0xA2, then silence -> packet starts when the gap counter reaches 20; exactly 3 bytes out; level=0.
- Push 0x01..0x06 with tx_en=1; during SEND toggle out_ready 1/0 each cycle -> out_data is held while out_ready=0; order 0x01..0x06 is preserved; no byte is duplicated or lost.
- tx_en=0, push 17 bytes:
  - level=16 and overflow=1; the 17th byte is absent on later readout.
  - ovf_clr gives overflow=0.
  - flush in IDLE gives level=0.
- Assert rst_n=0 mid-SEND -> out_valid=0, aux=0, level=0 immediately; the self-check window restarts.
